spi_shift_engine: RTL
=====================

Name: spi_shift_engine

Overview:
- SPI master shift engine sitting directly downstream of the SPI ring buffer's core port.
- Pops transmit words from the buffer and serialises them on MOSI while sampling MISO.
- Pushes each received word back into the buffer.
- Supports all four CPOL/CPHA modes, a programmable SCLK divider and back-to-back bursts under one chip-select assertion.

Parameters:
- DATAWIDTH, 8, word width in bits; must match the ring buffer.
- DIVWIDTH, 16, width of the clock-divider control.
- CSHOLD, 2, idle clk cycles csN stays high between frames, minimum 1.

Ports:
- clk  input  1  system clock
- reset  input  1  reset, asynchronous, active-high
- enable  input  1  engine may start new frames when high
- cpol  input  1  SCLK idle level
- cpha  input  1  0 = sample on leading edge; 1 = sample on trailing edge
- clockDivider  input  DIVWIDTH  SCLK half-period = clockDivider+1 clk cycles
- txData  input  DATAWIDTH  buffer core read data (registered memory output, 1-cycle latency)
- txDataReady  input  1  buffer holds an unsent transmit word
- txRead  output  1  one-cycle pulse: advance buffer core read pointer
- rxData  output  DATAWIDTH  received word presented to the buffer core write port
- rxWrite  output  1  one-cycle pulse: write rxData, advance core write pointer
- sclk  output  1  SPI clock
- mosi  output  1  SPI data out
- miso  input  1  SPI data in
- csN  output  1  chip select, active low
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse when a word completes (same cycle as rxWrite)

Behaviour:
- Reset values: state IDLE; sclk=0, mosi=0, csN=1, txRead=0, rxWrite=0, done=0, busy=0, rxData=0; all counters 0.
- Reset is honoured mid-frame: the frame is abandoned, csN rises immediately, and no rxWrite is issued.
- IDLE:
  - sclk tracks cpol every cycle.
  - Exit to FETCH when enable && txDataReady.
  - cpol, cpha and clockDivider are latched into frame registers on this transition and held until the return to IDLE.
- FETCH: one wait cycle so the buffer's registered txData is valid.
- LATCH:
  - Load the shift register from txData and pulse txRead in the same cycle.
  - If csN=1, go to CS_SETUP; otherwise go straight to SHIFT (burst).
- CS_SETUP: drive csN=0, wait one half-period, then go to SHIFT.
  - CPHA=0: mosi is driven with the first bit on entry to CS_SETUP.
- SHIFT:
  - The half-period counter counts 0..div; at div it resets and sclk toggles (one edge).
  - A word uses exactly 2*DATAWIDTH edges, tracked by an edge counter.
  - Odd edges are leading, even edges are trailing.
  - CPHA=0: sample miso on leading edges; shift mosi on trailing edges except the last.
  - CPHA=1: shift mosi on leading edges (the first leading edge drives the first bit); sample on trailing edges.
  - After the final edge, go to STORE. sclk is back at cpol.
- STORE:
  - rxData takes the assembled word; pulse rxWrite and done.
  - If enable && txDataReady, go to FETCH with csN held low (burst).
  - Otherwise go to CS_HOLD.
- CS_HOLD: wait one half-period with csN low, then raise csN and wait CSHOLD cycles, then go to IDLE.
- Bit order: MSB first (see the optional feature).
- Divider arithmetic: unsigned; clockDivider=0 gives SCLK = clk/2.
- Boundary conditions:
  - txDataReady dropping during SHIFT has no effect.
  - enable low mid-frame completes the current word and then ends the burst.
  - txRead is never issued when txDataReady=0.
  - Exactly one txRead and one rxWrite occur per word.

Optional Feature:
- Macro: SPI_LSB_FIRST_EN.
- When defined: adds input port lsbFirst (1 bit), latched at IDLE exit. When 1, bit 0 is shifted out first and received bits fill from the MSB downward.
- When undefined: the port is absent and operation is MSB-first only.

Decomposition:
- Package spi_pkg holds:
  - state enum spiState_t {IDLE, FETCH, LATCH, CS_SETUP, SHIFT, STORE, CS_HOLD};
  - default DATAWIDTH/DIVWIDTH constants shared with the ring buffer.
- Sub-module spi_clock_gen is natural: half-period counter plus edge counter.
  - Inputs: run, divider, cpol.
  - Outputs: sclk, leadingEdge, trailingEdge, lastEdge pulses.

Test Plan:
- Mode 0, div=1, txDataReady held for one word 0xA5, miso looped to mosi:
  - exactly 1 txRead; csN low for the frame;
  - 8 SCLK periods of 4 clk each;
  - rxWrite with rxData=0xA5; done pulse.
- Modes 1/2/3 with slave model returning 0x3C while master sends 0xC3:
  - mosi bits change only on the correct edges;
  - rxData=0x3C in every mode;
  - sclk idles at cpol.
- Burst of 3 words 0x01, 0x02, 0x03 preloaded:
  - csN stays low across all 3;
  - 3 txRead and 3 rxWrite pulses;
  - then csN high for at least CSHOLD cycles; busy drops.
- Reset asserted at edge 5 of a word:
  - next cycle csN=1, sclk=0, busy=0;
  - no rxWrite; engine restarts cleanly on the following frame.
- enable=0 with txDataReady=1: no activity. Then enable dropped mid-burst: current word completes and the burst ends.
- With SPI_LSB_FIRST_EN and lsbFirst=1, send 0x80: mosi shows 0 on the first 7 bits and 1 on the last.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and default widths for the SPI shift engine and its ring buffer.
package spi_pkg;

   localparam int unsigned SPI_DATAWIDTH = 8;
   localparam int unsigned SPI_DIVWIDTH  = 16;
   localparam int unsigned SPI_CSHOLD    = 2;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      FETCH    = 3'd1,
      LATCH    = 3'd2,
      CS_SETUP = 3'd3,
      SHIFT    = 3'd4,
      STORE    = 3'd5,
      CS_HOLD  = 3'd6
   } spiState_t;

endpackage

// File: rtl/spi_clock_gen.sv
// SCLK generator: half-period counter plus per-word edge counter.
// Edge pulses are combinational and coincide with the clk edge on which sclk toggles.
module spi_clock_gen
   import spi_pkg::*;
#(
   parameter int unsigned DATAWIDTH = SPI_DATAWIDTH,
   parameter int unsigned DIVWIDTH  = SPI_DIVWIDTH
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                run_i,
   input  logic [DIVWIDTH-1:0] divider_i,
   input  logic                cpol_i,
   output logic                sclk_o,
   output logic                leading_edge_c_o,
   output logic                trailing_edge_c_o,
   output logic                last_edge_c_o
);

   localparam int unsigned EDGES = 2 * DATAWIDTH;
   localparam int unsigned ECW   = $clog2(EDGES);

   logic [DIVWIDTH-1:0] half_q, half_d;
   logic [ECW-1:0]      edge_q, edge_d;
   logic                sclk_q, sclk_d;
   logic                edge_c;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         half_q <= '0;
         edge_q <= '0;
         sclk_q <= 1'b0;
      end else begin
         half_q <= half_d;
         edge_q <= edge_d;
         sclk_q <= sclk_d;
      end
   end

   // Outside a word sclk rests at the idle level and both counters clear.
   always_comb begin
      half_d = '0;
      edge_d = '0;
      sclk_d = cpol_i;
      edge_c = run_i && (half_q == divider_i);
      if (run_i) begin
         if (edge_c) begin
            sclk_d = ~sclk_q;
            edge_d = edge_q + ECW'(1);
         end else begin
            sclk_d = sclk_q;
            half_d = half_q + DIVWIDTH'(1);
            edge_d = edge_q;
         end
      end
   end

   // Edge number is edge_q+1, so an even edge_q marks an odd (leading) edge.
   assign leading_edge_c_o  = edge_c && !edge_q[0];
   assign trailing_edge_c_o = edge_c &&  edge_q[0];
   assign last_edge_c_o     = edge_c && (edge_q == ECW'(EDGES - 1));
   assign sclk_o            = sclk_q;

endmodule

// File: rtl/spi_shift_engine.sv
// SPI master shift engine between the ring buffer core port and the SPI pins.
// Optional SPI_LSB_FIRST_EN adds the lsbFirst input for LSB-first framing.
module spi_shift_engine
   import spi_pkg::*;
#(
   parameter int unsigned DATAWIDTH = SPI_DATAWIDTH,
   parameter int unsigned DIVWIDTH  = SPI_DIVWIDTH,
   parameter int unsigned CSHOLD    = SPI_CSHOLD
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 cpol,
   input  logic                 cpha,
   input  logic [DIVWIDTH-1:0]  clockDivider,
`ifdef SPI_LSB_FIRST_EN
   input  logic                 lsbFirst,
`endif
   input  logic [DATAWIDTH-1:0] txData,
   input  logic                 txDataReady,
   output logic                 txRead,
   output logic [DATAWIDTH-1:0] rxData,
   output logic                 rxWrite,
   output logic                 sclk,
   output logic                 mosi,
   input  logic                 miso,
   output logic                 csN,
   output logic                 busy,
   output logic                 done
);

   localparam int unsigned HOLD_W = $clog2(CSHOLD + 1);
   localparam int unsigned WAIT_W = (DIVWIDTH > HOLD_W) ? DIVWIDTH : HOLD_W;

   spiState_t             state_q, state_d;
   logic [WAIT_W-1:0]     cnt_q, cnt_d;
   logic [DATAWIDTH-1:0]  sh_q, sh_d;
   logic [DATAWIDTH-1:0]  rx_q, rx_d;
   logic [DATAWIDTH-1:0]  rx_data_q, rx_data_d;
   logic [DIVWIDTH-1:0]   div_q, div_d;
   logic                  cpol_q, cpol_d;
   logic                  cpha_q, cpha_d;
   logic                  cs_n_q, cs_n_d;
   logic                  mosi_q, mosi_d;
   logic                  tx_read_q, tx_read_d;
   logic                  rx_write_q, rx_write_d;
   logic                  done_q, done_d;
   logic                  busy_q, busy_d;

   logic                  start_c;
   logic                  lsb_first;
   logic                  gen_cpol;
   logic                  lead_c, trail_c, last_c;

   function automatic logic first_bit(input logic [DATAWIDTH-1:0] v, input logic lsb);
      return lsb ? v[0] : v[DATAWIDTH-1];
   endfunction

   function automatic logic [DATAWIDTH-1:0] shift_out(input logic [DATAWIDTH-1:0] v,
                                                      input logic lsb);
      return lsb ? {1'b0, v[DATAWIDTH-1:1]} : {v[DATAWIDTH-2:0], 1'b0};
   endfunction

   function automatic logic [DATAWIDTH-1:0] shift_in(input logic [DATAWIDTH-1:0] v,
                                                     input logic b, input logic lsb);
      return lsb ? {b, v[DATAWIDTH-1:1]} : {v[DATAWIDTH-2:0], b};
   endfunction

   assign start_c = (state_q == IDLE) && enable && txDataReady;

`ifdef SPI_LSB_FIRST_EN
   logic lsb_first_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lsb_first_q <= 1'b0;
      end else if (start_c) begin
         lsb_first_q <= lsbFirst;
      end
   end

   assign lsb_first = lsb_first_q;
`else
   assign lsb_first = 1'b0;
`endif

   // In IDLE sclk follows the live cpol; during a frame it uses the latched copy.
   assign gen_cpol = (state_q == IDLE) ? cpol : cpol_q;

   spi_clock_gen #(
      .DATAWIDTH (DATAWIDTH),
      .DIVWIDTH  (DIVWIDTH)
   ) u_clock_gen (
      .clk               (clk),
      .reset             (reset),
      .run_i             (state_q == SHIFT),
      .divider_i         (div_q),
      .cpol_i            (gen_cpol),
      .sclk_o            (sclk),
      .leading_edge_c_o  (lead_c),
      .trailing_edge_c_o (trail_c),
      .last_edge_c_o     (last_c)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         sh_q       <= '0;
         rx_q       <= '0;
         rx_data_q  <= '0;
         div_q      <= '0;
         cpol_q     <= 1'b0;
         cpha_q     <= 1'b0;
         cs_n_q     <= 1'b1;
         mosi_q     <= 1'b0;
         tx_read_q  <= 1'b0;
         rx_write_q <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sh_q       <= sh_d;
         rx_q       <= rx_d;
         rx_data_q  <= rx_data_d;
         div_q      <= div_d;
         cpol_q     <= cpol_d;
         cpha_q     <= cpha_d;
         cs_n_q     <= cs_n_d;
         mosi_q     <= mosi_d;
         tx_read_q  <= tx_read_d;
         rx_write_q <= rx_write_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sh_d      = sh_q;
      rx_d      = rx_q;
      rx_data_d = rx_data_q;
      div_d     = div_q;
      cpol_d    = cpol_q;
      cpha_d    = cpha_q;
      cs_n_d    = cs_n_q;
      mosi_d    = mosi_q;

      unique case (state_q)
         IDLE: begin
            if (start_c) begin
               state_d = FETCH;
               cpol_d  = cpol;
               cpha_d  = cpha;
               div_d   = clockDivider;
            end
         end
         FETCH: state_d = LATCH;
         LATCH: begin
            sh_d  = txData;
            cnt_d = '0;
            if (!cpha_q) begin
               mosi_d = first_bit(txData, lsb_first);
            end
            // A low csN here means we are mid-burst and skip the setup delay.
            if (cs_n_q) begin
               state_d = CS_SETUP;
               cs_n_d  = 1'b0;
            end else begin
               state_d = SHIFT;
            end
         end
         CS_SETUP: begin
            if (cnt_q == WAIT_W'(div_q)) begin
               cnt_d   = '0;
               state_d = SHIFT;
            end else begin
               cnt_d = cnt_q + WAIT_W'(1);
            end
         end
         SHIFT: begin
            if (lead_c) begin
               if (!cpha_q) begin
                  rx_d = shift_in(rx_q, miso, lsb_first);
               end else begin
                  mosi_d = first_bit(sh_q, lsb_first);
                  sh_d   = shift_out(sh_q, lsb_first);
               end
            end
            if (trail_c) begin
               if (cpha_q) begin
                  rx_d = shift_in(rx_q, miso, lsb_first);
               end else if (!last_c) begin
                  sh_d   = shift_out(sh_q, lsb_first);
                  mosi_d = first_bit(shift_out(sh_q, lsb_first), lsb_first);
               end
            end
            if (last_c) begin
               state_d = STORE;
            end
         end
         STORE: begin
            if (enable && txDataReady) begin
               state_d = FETCH;
            end else begin
               state_d = CS_HOLD;
               cnt_d   = '0;
            end
         end
         CS_HOLD: begin
            // csN itself distinguishes the low half-period from the high guard time.
            if (!cs_n_q) begin
               if (cnt_q == WAIT_W'(div_q)) begin
                  cs_n_d = 1'b1;
                  cnt_d  = '0;
               end else begin
                  cnt_d = cnt_q + WAIT_W'(1);
               end
            end else if (cnt_q == WAIT_W'(CSHOLD - 1)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + WAIT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Registered strobes line up with the state they belong to.
      tx_read_d  = (state_d == LATCH);
      rx_write_d = (state_d == STORE);
      done_d     = (state_d == STORE);
      busy_d     = (state_d != IDLE);
      if (state_d == STORE) begin
         rx_data_d = rx_d;
      end
   end

   assign txRead  = tx_read_q;
   assign rxData  = rx_data_q;
   assign rxWrite = rx_write_q;
   assign mosi    = mosi_q;
   assign csN     = cs_n_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule
